// File: rtl/adc_spi_pkg.sv
// Shared constants, state encoding and MOSI word builder for the ADC SPI responder.
package adc_spi_pkg;

    localparam int unsigned LEAD_BITS    = 4;
    localparam int unsigned DATA_BITS    = 12;
    localparam int unsigned FRAME_BITS   = LEAD_BITS + DATA_BITS;
    localparam int unsigned CH_BITS      = 5;
    localparam int unsigned HDR_BITS     = 3;
    localparam int unsigned CNT_BITS     = 8;
    localparam int unsigned BIT_IDX_BITS = 4;

    localparam logic [HDR_BITS-1:0] CMD_HDR_DEF = 3'b100;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t SETUP = 3'd1;
    localparam state_t SHIFT = 3'd2;
    localparam state_t HOLD  = 3'd3;
    localparam state_t RESP  = 3'd4;

    // Command word shifted out on MOSI, MSB first.
    function automatic logic [FRAME_BITS-1:0] mosi_word(input logic [HDR_BITS-1:0] hdr,
                                                        input logic [CH_BITS-1:0]  ch);
        return {hdr, ch, 8'h00};
    endfunction

endpackage

// File: rtl/adc_sclk_phase_gen.sv
// CLK_DIV phase timer shared by SETUP/SHIFT/HOLD; owns the registered SCLK level.
module adc_sclk_phase_gen
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic sclk_next,
    output logic phase_end_c,
    output logic sclk
);

    logic [CNT_BITS-1:0] cnt;

    // A load starts a new phase: reload the divider and apply the phase's SCLK level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (load) begin
            cnt  <= CNT_BITS'(CLK_DIV - 1);
            sclk <= sclk_next;
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_BITS'(1);
        end
    end

    assign phase_end_c = (cnt == '0);

endmodule

// File: rtl/adc_spi_responder.sv
// Command-stream to serial-ADC responder: one SPI frame and one response beat per command.
// Define ADC_LOOPBACK_EN to return the latched channel instead of captured MISO data.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned          CLK_DIV = 2,
    parameter logic [HDR_BITS-1:0]  CMD_HDR = CMD_HDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_BITS-1:0]    cmd_channel,
    input  logic                  cmd_startofpacket,
    input  logic                  cmd_endofpacket,
    output logic                  resp_valid,
    output logic [DATA_BITS-1:0]  resp_data,
    output logic [CH_BITS-1:0]    resp_channel,
    output logic                  resp_startofpacket,
    output logic                  resp_endofpacket,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    output logic                  adc_mosi,
    input  logic                  adc_miso
);

    state_t                   state, state_d;
    logic [CH_BITS-1:0]       ch_q, ch_d;
    logic                     sop_q, sop_d, eop_q, eop_d;
    logic [BIT_IDX_BITS-1:0]  bit_idx, bit_idx_d, bit_prev;
    logic                     cmd_ready_d, cs_n_d, mosi_d, resp_valid_d;
    logic [DATA_BITS-1:0]     resp_data_d;
    logic [CH_BITS-1:0]       resp_channel_d;
    logic                     resp_sop_d, resp_eop_d;
    logic                     load, sclk_next, phase_end;
    logic [FRAME_BITS-1:0]    frame_word;

`ifndef ADC_LOOPBACK_EN
    // Only the last DATA_BITS samples survive, so the lead bits fall off the top.
    logic [DATA_BITS-1:0]     shift_q, shift_d;
`else
    logic                     unused_miso;
    assign unused_miso = adc_miso;
`endif

    assign frame_word = mosi_word(CMD_HDR, ch_q);
    assign bit_prev   = bit_idx - BIT_IDX_BITS'(1);

    adc_sclk_phase_gen #(
        .CLK_DIV     (CLK_DIV)
    ) u_phase (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .sclk_next   (sclk_next),
        .phase_end_c (phase_end),
        .sclk        (adc_sclk)
    );

    // Next-state and next-output logic; SHIFT low/high phase is read back from SCLK.
    always_comb begin
        state_d        = state;
        ch_d           = ch_q;
        sop_d          = sop_q;
        eop_d          = eop_q;
        bit_idx_d      = bit_idx;
        cs_n_d         = adc_cs_n;
        mosi_d         = adc_mosi;
        resp_valid_d   = 1'b0;
        resp_data_d    = resp_data;
        resp_channel_d = resp_channel;
        resp_sop_d     = resp_startofpacket;
        resp_eop_d     = resp_endofpacket;
        load           = 1'b0;
        sclk_next      = 1'b1;
`ifndef ADC_LOOPBACK_EN
        shift_d        = shift_q;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d   = SETUP;
                    ch_d      = cmd_channel;
                    sop_d     = cmd_startofpacket;
                    eop_d     = cmd_endofpacket;
                    bit_idx_d = BIT_IDX_BITS'(FRAME_BITS - 1);
                    cs_n_d    = 1'b0;
                    mosi_d    = CMD_HDR[HDR_BITS-1];
                    load      = 1'b1;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d   = SHIFT;
                    load      = 1'b1;
                    sclk_next = 1'b0;
                    mosi_d    = frame_word[bit_idx];
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    load = 1'b1;
                    if (!adc_sclk) begin
                        sclk_next = 1'b1;
`ifndef ADC_LOOPBACK_EN
                        shift_d   = {shift_q[DATA_BITS-2:0], adc_miso};
`endif
                    end else if (bit_idx == '0) begin
                        state_d   = HOLD;
                        sclk_next = 1'b1;
                    end else begin
                        bit_idx_d = bit_prev;
                        sclk_next = 1'b0;
                        mosi_d    = frame_word[bit_prev];
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d        = RESP;
                    cs_n_d         = 1'b1;
                    mosi_d         = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_channel_d = ch_q;
                    resp_sop_d     = sop_q;
                    resp_eop_d     = eop_q;
`ifdef ADC_LOOPBACK_EN
                    resp_data_d    = {{(DATA_BITS - CH_BITS){1'b0}}, ch_q};
`else
                    resp_data_d    = shift_q;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            ch_q               <= '0;
            sop_q              <= 1'b0;
            eop_q              <= 1'b0;
            bit_idx            <= '0;
            cmd_ready          <= 1'b0;
            adc_cs_n           <= 1'b1;
            adc_mosi           <= 1'b0;
            resp_valid         <= 1'b0;
            resp_data          <= '0;
            resp_channel       <= '0;
            resp_startofpacket <= 1'b0;
            resp_endofpacket   <= 1'b0;
`ifndef ADC_LOOPBACK_EN
            shift_q            <= '0;
`endif
        end else begin
            state              <= state_d;
            ch_q               <= ch_d;
            sop_q              <= sop_d;
            eop_q              <= eop_d;
            bit_idx            <= bit_idx_d;
            cmd_ready          <= cmd_ready_d;
            adc_cs_n           <= cs_n_d;
            adc_mosi           <= mosi_d;
            resp_valid         <= resp_valid_d;
            resp_data          <= resp_data_d;
            resp_channel       <= resp_channel_d;
            resp_startofpacket <= resp_sop_d;
            resp_endofpacket   <= resp_eop_d;
`ifndef ADC_LOOPBACK_EN
            shift_q            <= shift_d;
`endif
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder at CLK_DIV=2 and CLK_DIV=1 with a serial ADC model.
module tb_adc_spi_responder;

    typedef struct packed {
        logic [11:0] data;
        logic [4:0]  ch;
        logic        sop;
        logic        eop;
    } resp_t;

    typedef struct packed {
        logic [15:0] adc_word;
        logic [15:0] mosi_word;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // DUT at CLK_DIV=2
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_channel = 5'd0;
    logic        cmd_startofpacket = 1'b0;
    logic        cmd_endofpacket = 1'b0;
    logic        resp_valid;
    logic [11:0] resp_data;
    logic [4:0]  resp_channel;
    logic        resp_startofpacket, resp_endofpacket;
    logic        adc_cs_n, adc_sclk, adc_mosi;
    logic        adc_miso = 1'b0;

    // DUT at CLK_DIV=1, MISO tied high
    logic        v1 = 1'b0;
    logic        ready1;
    logic [4:0]  ch1 = 5'd0;
    logic        sop1 = 1'b0;
    logic        eop1 = 1'b0;
    logic        resp1_valid;
    logic [11:0] resp1_data;
    logic [4:0]  resp1_channel;
    logic        resp1_sop, resp1_eop;
    logic        cs1_n, sclk1, mosi1;
    logic        miso1 = 1'b1;

    adc_spi_responder #(.CLK_DIV(2)) dut (
        .clk(clk), .reset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_channel(cmd_channel),
        .cmd_startofpacket(cmd_startofpacket), .cmd_endofpacket(cmd_endofpacket),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_channel(resp_channel),
        .resp_startofpacket(resp_startofpacket), .resp_endofpacket(resp_endofpacket),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso)
    );

    adc_spi_responder #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(rst),
        .cmd_valid(v1), .cmd_ready(ready1), .cmd_channel(ch1),
        .cmd_startofpacket(sop1), .cmd_endofpacket(eop1),
        .resp_valid(resp1_valid), .resp_data(resp1_data), .resp_channel(resp1_channel),
        .resp_startofpacket(resp1_sop), .resp_endofpacket(resp1_eop),
        .adc_cs_n(cs1_n), .adc_sclk(sclk1), .adc_mosi(mosi1), .adc_miso(miso1)
    );

    resp_t  exp_q[$];
    int     acc_q[$];
    frame_t fq[$];
    resp_t  exp1_q[$];
    int     acc1_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Accept recorders
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (!rst && v1 && ready1) acc1_q.push_back(cyc);
    end

    // Response monitor, CLK_DIV=2
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got resp ch=%0d data=0x%0h, expected none", resp_channel, resp_data);
            end else begin
                resp_t e;
                int    a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_channel", resp_channel, e.ch);
                chk("resp_sop", resp_startofpacket, e.sop);
                chk("resp_eop", resp_endofpacket, e.eop);
                chk("latency_div2", cyc - a, 69);
            end
        end
    end

    // Response monitor, CLK_DIV=1
    always @(negedge clk) begin
        if (resp1_valid) begin
            if (exp1_q.size() == 0 || acc1_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp1: got resp ch=%0d data=0x%0h, expected none", resp1_channel, resp1_data);
            end else begin
                resp_t e;
                int    a;
                e = exp1_q.pop_front();
                a = acc1_q.pop_front();
                chk("resp1_data", resp1_data, e.data);
                chk("resp1_channel", resp1_channel, e.ch);
                chk("resp1_eop", resp1_eop, e.eop);
                chk("latency_div1", cyc - a, 35);
            end
        end
    end

    // Chip-select gap between frames
    int gap = 0;
    bit seen_frame = 0;
    always @(negedge clk) begin
        if (adc_cs_n) gap++;
        else begin
            if (seen_frame && gap > 0) begin
                checks++;
                if (gap >= 2) passed++;
                else $display("FAIL cs_gap: got %0d cycles expected >=2", gap);
            end
            gap = 0;
            seen_frame = 1;
        end
    end

    // Serial ADC model: shifts its word out on SCLK fall, captures MOSI on SCLK rise
    logic [15:0] adc_word = '0, exp_mosi = '0, mosi_cap = '0;
    int          idx = 0, rise_cnt = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1;
    bit          in_frame = 0;
    always @(adc_cs_n or adc_sclk) begin
        if (cs_prev === 1'b1 && adc_cs_n === 1'b0) begin
            frame_t f;
            f = (fq.size() > 0) ? fq.pop_front() : '0;
            adc_word = f.adc_word;
            exp_mosi = f.mosi_word;
            idx = 15; rise_cnt = 0; mosi_cap = '0; in_frame = 1;
        end else if (cs_prev === 1'b0 && adc_cs_n === 1'b1) begin
            if (in_frame && !rst) begin
                chk("mosi_word", mosi_cap, exp_mosi);
                chk("sclk_rises", rise_cnt, 16);
            end
            in_frame = 0;
        end
        if (adc_cs_n === 1'b0 && sclk_prev === 1'b1 && adc_sclk === 1'b0 && idx >= 0) begin
            adc_miso = adc_word[idx];
            idx--;
        end
        if (adc_cs_n === 1'b0 && sclk_prev === 1'b0 && adc_sclk === 1'b1) begin
            mosi_cap = {mosi_cap[14:0], adc_mosi};
            rise_cnt++;
        end
        cs_prev = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    task automatic issue(input logic [4:0] ch, input logic sop, input logic eop,
                         input logic [15:0] word, output int acc);
        resp_t  e;
        frame_t f;
        cmd_channel = ch; cmd_startofpacket = sop; cmd_endofpacket = eop; cmd_valid = 1'b1;
`ifdef ADC_LOOPBACK_EN
        e.data = {7'b0, ch};
`else
        e.data = word[11:0];
`endif
        e.ch = ch; e.sop = sop; e.eop = eop;
        exp_q.push_back(e);
        f.adc_word = word;
        f.mosi_word = {3'b100, ch, 8'h00};
        fq.push_back(f);
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = cyc; break; end
        end
        if (acc < 0) begin
            checks++;
            $display("FAIL accept_timeout: got no cmd_ready for ch %0d, expected accept", ch);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp1_q.size() == 0) begin done = 1; break; end
        end
        if (!done) begin
            checks++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", exp_q.size(), exp1_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        bit found;
        resp_t e1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 1);
        chk("rst_mosi", adc_mosi, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("ready_before_edge", cmd_ready, 0);
        @(negedge clk); chk("ready_after_release", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_cs_n", adc_cs_n, 1);
            chk("idle_sclk", adc_sclk, 1);
        end
        @(posedge clk); #1;

        // Single command, ADC returns 0x0ABC
        issue(5'd3, 1'b1, 1'b1, 16'h0ABC, a0);
        cmd_valid = 1'b0;
        drain(400);
        repeat (3) @(negedge clk);
`ifdef ADC_LOOPBACK_EN
        chk("resp_data_hold", resp_data, 12'h003);
`else
        chk("resp_data_hold", resp_data, 12'hABC);
`endif
        chk("resp_channel_hold", resp_channel, 3);
        @(posedge clk); #1;

        // cmd_valid pulses while busy must not be taken
        issue(5'd12, 1'b0, 1'b0, 16'h0123, a0);
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 cmd_valid = 1'b1; cmd_channel = 5'd31;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        drain(400);

        // Back-to-back sequence with cmd_valid held
        issue(5'd1, 1'b1, 1'b0, 16'h0111, a0);
        issue(5'd2, 1'b0, 1'b0, 16'h0F22, a1);
        issue(5'd7, 1'b0, 1'b1, 16'h5777, a2);
        cmd_valid = 1'b0;
        chk("accept_spacing_1", a1 - a0, 70);
        chk("accept_spacing_2", a2 - a1, 70);
        drain(400);

        // Reset during SHIFT at bit 9
        issue(5'd4, 1'b1, 1'b0, 16'h0FFF, a0);
        cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!adc_cs_n && rise_cnt == 6 && !adc_sclk) begin found = 1; break; end
        end
        if (!found) begin
            checks++;
            $display("FAIL bit9_timeout: got rise_cnt=%0d expected 6", rise_cnt);
        end
        rst = 1'b1;
        #1;
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_sclk", adc_sclk, 1);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_resp_data", resp_data, 0);
        chk("abort_resp_channel", resp_channel, 0);
        exp_q.delete(); acc_q.delete(); fq.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_resp", resp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        issue(5'd6, 1'b0, 1'b1, 16'h0456, a0);
        cmd_valid = 1'b0;
        drain(400);

        // CLK_DIV=1, MISO all ones
        ch1 = 5'd9; sop1 = 1'b0; eop1 = 1'b1; v1 = 1'b1;
`ifdef ADC_LOOPBACK_EN
        e1.data = 12'h009;
`else
        e1.data = 12'hFFF;
`endif
        e1.ch = 5'd9; e1.sop = 1'b0; e1.eop = 1'b1;
        exp1_q.push_back(e1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready1) begin found = 1; break; end
        end
        if (!found) begin
            checks++;
            $display("FAIL accept1_timeout: got no ready1, expected accept");
        end
        @(posedge clk); #1 v1 = 1'b0;
        drain(200);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size() + exp1_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
